// File: rtl/bulk_tx_arbiter.sv
// Round-robin burst arbiter that merges NUM_REQ valid/ready write streams into one registered stream.
// Define BULK_TX_ARB_PRIO_EN to give requester 0 strict priority with unlimited bursts.

module bulk_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ADDR_WIDTH-1:0]         out_addr,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = 4;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_next;
  logic [GW-1:0]   last_grant, last_next, grant_next, rr_pick, cand;
  logic [CW-1:0]   burst_cnt;
  logic            slot_ready, transfer, burst_done, burst_limited, release_grant;

  logic [ADDR_WIDTH-1:0] addr_slice [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_slice [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign addr_slice[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_slice[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan from farthest to nearest so the last hit is the first valid requester after last_grant.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    rr_pick = last_grant;
    cand    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = GW'((int'(last_grant) + k) % NUM_REQ);
      if (req_valid[cand]) rr_pick = cand;
    end
`ifdef BULK_TX_ARB_PRIO_EN
    if (req_valid[0]) rr_pick = '0;
`endif
  end

`ifdef BULK_TX_ARB_PRIO_EN
  assign burst_limited = (grant_id != '0);
`else
  assign burst_limited = 1'b1;
`endif

  // The granted slot can take a beat whenever the output register is empty or draining.
  assign slot_ready    = !out_valid || out_ready;
  assign transfer      = (state == GRANT) && req_valid[grant_id] && slot_ready;
  assign burst_done    = (burst_cnt == CW'(MAX_BURST - 1));
  assign release_grant = !req_valid[grant_id] || (transfer && burst_limited && burst_done);
  assign busy          = (state == GRANT) || out_valid;

  always_comb begin
    req_ready = '0;
    if (state == GRANT) req_ready[grant_id] = slot_ready;
  end

  always_comb begin
    state_next = state;
    grant_next = grant_id;
    last_next  = last_grant;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          state_next = GRANT;
          grant_next = rr_pick;
        end
      end
      GRANT: begin
        if (release_grant) begin
          state_next = IDLE;
          last_next  = grant_id;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: the output data registers are reset as well, so a held beat never survives reset.
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      burst_cnt  <= '0;
      out_valid  <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_next;
      grant_id   <= grant_next;
      last_grant <= last_next;

      if (state == IDLE && |req_valid) burst_cnt <= '0;
      else if (transfer)               burst_cnt <= burst_cnt + 1'b1;

      if (transfer) begin
        out_valid <= 1'b1;
        out_addr  <= addr_slice[grant_id];
        out_data  <= data_slice[grant_id];
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/bulk_tx_arbiter.md
BULK_TX_ARBITER -- requirements
Module: bulk_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the UART bulk-tx write bus (legal range 2..8).
REQ-002 SHALL have parameter MAX_BURST, default 4, the maximum number of transfers per grant (legal range 1..15).
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, the address width; parameter DATA_WIDTH, default 32, the data width.
REQ-004 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-005 SHALL have port rstn, input, 1, reset; reset rstn, synchronous, active-low; clock clk.
REQ-006 SHALL have port req_valid, input, NUM_REQ, per-requester valid.
REQ-007 SHALL have port req_ready, output, NUM_REQ, per-requester ready.
REQ-008 SHALL have port req_addr, input, NUM_REQ*ADDR_WIDTH, packed addresses; requester i occupies slice i.
REQ-009 SHALL have port req_data, input, NUM_REQ*DATA_WIDTH, packed data; requester i occupies slice i.
REQ-010 SHALL have port out_valid, output, 1, merged-stream valid toward the UART tx controller.
REQ-011 SHALL have port out_ready, input, 1, merged-stream ready.
REQ-012 SHALL have port out_addr, output, ADDR_WIDTH, registered address.
REQ-013 SHALL have port out_data, output, DATA_WIDTH, registered data.
REQ-014 SHALL have port grant_id, output, clog2(NUM_REQ), index of the current or last granted requester.
REQ-015 SHALL have port busy, output, 1, high while in GRANT state or while out_valid is high.

Function
REQ-016 SHALL implement a two-state FSM with states IDLE and GRANT.
REQ-017 In IDLE, when any req_valid is high, SHALL select the first requester with valid high, searching upward from (last_grant+1) mod NUM_REQ with wrap-around; SHALL latch it into grant_id, clear burst_cnt and enter GRANT on the next edge.
REQ-018 In IDLE, all req_ready SHALL be 0.
REQ-019 In GRANT, req_ready[grant_id] SHALL equal (!out_valid || out_ready); all other req_ready bits SHALL be 0.
REQ-020 A transfer SHALL occur when req_valid[grant_id] and req_ready[grant_id] are both high; it SHALL load out_addr/out_data from slice grant_id, set out_valid=1 and increment burst_cnt.
REQ-021 out_valid SHALL clear after out_valid and out_ready are both high, unless a transfer occurs in the same cycle; a simultaneous drain and load SHALL keep out_valid=1 with the new data.
REQ-022 out_addr/out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 Release condition 1: a transfer with burst_cnt==MAX_BURST-1 SHALL release the grant.
REQ-024 Release condition 2: req_valid[grant_id]=0 while in GRANT SHALL release the grant.
REQ-025 On release, the FSM SHALL return to IDLE and set last_grant=grant_id.
REQ-026 Requester-to-output latency SHALL be 1 cycle; arbitration SHALL cost 1 IDLE cycle per grant.
REQ-027 Valid inputs on non-granted requesters SHALL be ignored until they are granted.
REQ-028 A requester that drops valid without a transfer SHALL lose its grant and move to the back of the round-robin order.
REQ-029 No data SHALL be dropped or duplicated; each accepted beat SHALL appear exactly once on the output.

Reset
REQ-030 On rstn=0, state SHALL be IDLE, and out_valid, out_addr, out_data, req_ready, busy, grant_id and burst_cnt SHALL be 0.
REQ-031 On rstn=0, last_grant SHALL be NUM_REQ-1, so that requester 0 is searched first after reset.
REQ-032 Reset asserted mid-burst SHALL discard the held output beat; the next grant after reset SHALL follow REQ-031.

Configuration
REQ-033 When macro BULK_TX_ARB_PRIO_EN is defined, requester 0 SHALL be strict-priority: in IDLE with req_valid[0]=1, requester 0 SHALL be granted regardless of last_grant, and its bursts SHALL be unlimited (release only per REQ-024).
REQ-034 When BULK_TX_ARB_PRIO_EN is undefined, all requesters SHALL be treated equally per REQ-017 and REQ-023.

Verification
REQ-035 Reset, then req_valid=4'b0001 with addr 0x10 and data 0xDEADBEEF, out_ready=1 -> grant_id=0; out_addr=0x10, out_data=0xDEADBEEF, out_valid=1 exactly two cycles after valid.
REQ-036 All four requesters continuously valid, MAX_BURST=4, out_ready=1 -> grants in order 0,1,2,3,0, with 4 beats each and one IDLE cycle between grants.
REQ-037 out_ready held 0 for 10 cycles with requester 2 granted -> out_data stable, req_ready[2]=0 after the first beat, no loss when out_ready returns to 1.
REQ-038 Requester 1 drops valid after 2 of 4 beats, requester 3 valid -> grant moves to 3, and requester 1 is next only after 3 (and 0 and 2 if valid).
REQ-039 rstn pulsed low mid-burst with out_valid=1 -> out_valid=0 the next cycle, and the first grant after reset goes to the lowest-index valid requester.
REQ-040 BULK_TX_ARB_PRIO_EN defined, requesters 0 and 2 valid, requester 0 sends 10 beats -> all 10 beats go to requester 0 before requester 2 is granted.
